// File: rtl/mem_access_ctrl.sv
// MEM-stage data-bus sequencer: alignment check, byte strobes, lane-shifted store data,
// dbus request/response tracking and result hold. Optional timeout: MEMCTRL_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [63:0] req_wdata,
    input  logic        flush,
    input  logic        ack,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output logic [2:0]  dreq_size,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_data,
    input  logic        dresp_ok,
    input  logic [63:0] dresp_data,
    output logic        stall,
    output logic        done,
    output logic [63:0] rdata_raw,
    output logic        misalign,
    output logic        bus_err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  lane;
    logic        aligned;
    logic [7:0]  strobe_calc;
    logic [63:0] data_calc;
    logic        accept;
    logic        timeout_hit;
    logic        write_q;
    logic        misalign_q;

    assign lane      = req_addr[2:0];
    assign data_calc = req_wdata << {lane, 3'b000};
    assign accept    = (state == IDLE) && req_valid && !flush;

    // Sizes above 8 bytes are not legal msize encodings; they are treated as doubleword.
    always_comb begin
        aligned     = 1'b1;
        strobe_calc = 8'h00;
        case (req_size)
            3'd0: begin
                aligned     = 1'b1;
                strobe_calc = 8'h01 << lane;
            end
            3'd1: begin
                aligned     = (lane[0] == 1'b0);
                strobe_calc = 8'h03 << {lane[2:1], 1'b0};
            end
            3'd2: begin
                aligned     = (lane[1:0] == 2'b00);
                strobe_calc = 8'h0F << {lane[2], 2'b00};
            end
            default: begin
                aligned     = (lane == 3'd0);
                strobe_calc = 8'hFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = aligned ? WAIT : HOLD;
                end
            end
            WAIT: begin
                // A flushed op whose response is still outstanding must drain it first.
                if (dresp_ok) begin
                    state_next = flush ? IDLE : HOLD;
                end else if (flush) begin
                    state_next = DRAIN;
                end else if (timeout_hit) begin
                    state_next = HOLD;
                end
            end
            DRAIN: begin
                if (dresp_ok) begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (ack || flush) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dreq_addr   <= 64'd0;
            dreq_size   <= 3'd0;
            dreq_strobe <= 8'd0;
            dreq_data   <= 64'd0;
            write_q     <= 1'b0;
            rdata_raw   <= 64'd0;
            misalign_q  <= 1'b0;
        end else begin
            if (accept) begin
                misalign_q <= !aligned;
                rdata_raw  <= 64'd0;
                if (aligned) begin
                    dreq_addr   <= req_addr;
                    dreq_size   <= req_size;
                    dreq_strobe <= req_write ? strobe_calc : 8'h00;
                    dreq_data   <= data_calc;
                    write_q     <= req_write;
                end
            end
            if ((state == WAIT) && dresp_ok && !flush) begin
                rdata_raw <= write_q ? 64'd0 : dresp_data;
            end
            if ((state == HOLD) && (ack || flush)) begin
                misalign_q <= 1'b0;
            end
        end
    end

`ifdef MEMCTRL_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_W-1:0] timer;
    logic               bus_err_q;

    assign timeout_hit = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
    assign bus_err     = bus_err_q;

    // The timer sits at zero outside WAIT, so it starts from zero on every WAIT entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (state == WAIT) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
            end
            if ((state == WAIT) && !dresp_ok && !flush && timeout_hit) begin
                bus_err_q <= 1'b1;
            end else if ((state == HOLD) && (ack || flush)) begin
                bus_err_q <= 1'b0;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign bus_err            = 1'b0;
`endif

    assign dreq_valid = (state == WAIT) || (state == DRAIN);
    assign done       = (state == HOLD);
    assign misalign   = misalign_q;
    assign stall      = req_valid && !done;
    assign state_dbg  = state;

endmodule
